// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes diff = a - b (mod 2^WIDTH) over
// WIDTH RUN cycles, LSB first, using one full-subtractor cell per cycle and a
// stored borrow between cycles.
//
// Handshake: a start seen while IDLE captures a/b on that rising edge. busy is
// high for the WIDTH cycles of RUN, then done pulses for exactly one cycle
// with diff/borrow_out already valid. start is ignored outside IDLE (no
// queuing). diff/borrow_out are held until the next result or reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      operation request, sampled only in IDLE
//   a, b       minuend / subtrahend, captured on accepted start
//   busy       high while in RUN
//   done       one-cycle pulse, result valid
//   diff       (a - b) mod 2^WIDTH, held between operations
//   borrow_out final borrow, 1 iff a < b (unsigned)
//   state_dbg  current FSM state encoding (IDLE=0, RUN=1, DONE=2)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  // One-hot-ish encoding so busy and done are straight flop bits.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_next;

  // a_sr holds the minuend; as its bits are consumed from the LSB end the
  // difference bits are shifted in at the MSB, so after WIDTH shifts it holds
  // the full result.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] a_shift;
  logic [CW-1:0]    count;
  logic             borrow_q;

  logic a0;
  logic b0;
  logic d;
  logic bo;
  logic last_bit;

  // Full-subtractor cell on the current LSBs.
  assign a0 = a_sr[0];
  assign b0 = b_sr[0];
  assign d  = a0 ^ b0 ^ borrow_q;
  assign bo = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);

  generate
    if (WIDTH == 1) begin : g_shift_w1
      assign a_shift = d;
    end else begin : g_shift_wn
      assign a_shift = {d, a_sr[WIDTH-1:1]};
    end
  endgenerate

  // Current edge consumes the final bit pair.
  assign last_bit = (count == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr       <= '0;
      b_sr       <= '0;
      count      <= '0;
      borrow_q   <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            count    <= '0;
            borrow_q <= 1'b0;
          end
        end
        RUN: begin
          a_sr     <= a_shift;
          b_sr     <= b_sr >> 1;
          borrow_q <= bo;
          count    <= count + CW'(1);
          if (last_bit) begin
            diff       <= a_shift;
            borrow_out <= bo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = state[0];
  assign done      = state[1];
  assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Exercises an 8-bit and a 1-bit serial_subtractor. Drivers push the expected
// {borrow, diff} into a queue when they issue an operation; monitors pop and
// compare whenever done pulses, and also check busy length and output hold.
// Stimulus changes at posedge+1; monitors sample on the negedge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic [1:0]   state_dbg;

  logic         start1;
  logic [0:0]   a1;
  logic [0:0]   b1;
  logic         busy1;
  logic         done1;
  logic [0:0]   diff1;
  logic         borrow_out1;
  logic [1:0]   state_dbg1;

  int tests = 0;
  int fails = 0;

  logic [W:0] exp_q[$];
  logic [1:0] exp1_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .state_dbg  (state_dbg)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow_out1),
    .state_dbg  (state_dbg1)
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model: plain (W+1)-bit subtraction; the top bit is the borrow.
  // ---------------------------------------------------------------------------
  function automatic logic [W:0] model8(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
    return r;
  endfunction

  function automatic logic [1:0] model1(input logic x, input logic y);
    logic [1:0] r;
    r = {1'b0, x} - {1'b0, y};
    return r;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (all called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy && !done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: busy=%0b done=%0b, required idle", busy, done);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: done=%0b, required a done pulse", done);
    end
  endtask

  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push);
    bit ok;
    wait_idle(ok);
    if (!ok) return;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) exp_q.push_back(model8(av, bv));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_op1(input logic av, input logic bv);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!busy1 && !done1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL idle1_timeout: busy1=%0b done1=%0b, required idle", busy1, done1);
      return;
    end
    a1     = av;
    b1     = bv;
    start1 = 1'b1;
    exp1_q.push_back(model1(av, bv));
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitors
  // ---------------------------------------------------------------------------
  logic [W:0] held;
  int         run_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      held    = '0;
      run_len = 0;
    end else begin
      if (busy) begin
        run_len++;
        tests++;
        if ({borrow_out, diff} !== held) begin
          fails++;
          $display("FAIL hold8: outputs 0x%0h changed during RUN, required 0x%0h",
                   {borrow_out, diff}, held);
        end
      end
      if (done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done8: result 0x%0h with no operation outstanding",
                   {borrow_out, diff});
        end else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          if ({borrow_out, diff} !== e) begin
            fails++;
            $display("FAIL result8: {borrow,diff}=0x%0h, required 0x%0h", {borrow_out, diff}, e);
          end
        end
        tests++;
        if (run_len != W) begin
          fails++;
          $display("FAIL busy_len8: busy for %0d cycles, required %0d", run_len, W);
        end
        held    = {borrow_out, diff};
        run_len = 0;
      end
    end
  end

  int run_len1;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len1 = 0;
    end else begin
      if (busy1) run_len1++;
      if (done1) begin
        tests++;
        if (exp1_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done1: result 0x%0h with no operation outstanding",
                   {borrow_out1, diff1});
        end else begin
          logic [1:0] e;
          e = exp1_q.pop_front();
          if ({borrow_out1, diff1} !== e) begin
            fails++;
            $display("FAIL result1: {borrow,diff}=0x%0h, required 0x%0h", {borrow_out1, diff1}, e);
          end
        end
        tests++;
        if (run_len1 != 1) begin
          fails++;
          $display("FAIL busy_len1: busy for %0d cycles, required 1", run_len1);
        end
        run_len1 = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_diff", int'(diff), 0);
    check("reset_borrow", int'(borrow_out), 0);
    check("reset_busy1", int'(busy1), 0);
    check("reset_diff1", int'({borrow_out1, diff1}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    do_op(8'h05, 8'h03, 1'b1);
    do_op(8'h03, 8'h05, 1'b1);
    do_op(8'h00, 8'h01, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1);

    // Start raised during the DONE cycle must be ignored.
    wait_done(ok);
    start = 1'b1;
    a     = 8'($urandom_range(0, 255));
    b     = 8'($urandom_range(0, 255));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("done_start_ignored_busy", int'(busy), 0);
    check("done_start_ignored_q", exp_q.size(), 0);
    do_op(8'h80, 8'h7F, 1'b1);

    // Start held high with operands churning during RUN: exactly one op.
    wait_idle(ok);
    a     = 8'h10;
    b     = 8'h01;
    start = 1'b1;
    exp_q.push_back(model8(8'h10, 8'h01));
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("held_start_single_op", exp_q.size(), 0);
    check("held_start_idle", int'(busy), 0);

    // Reset during RUN cycle 4: everything clears, no done follows.
    do_op(8'h20, 8'h01, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midrun_busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_done", int'(done), 0);
    check("midrun_reset_diff", int'(diff), 0);
    check("midrun_reset_borrow", int'(borrow_out), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("post_reset_idle", int'(busy), 0);
    do_op(8'h20, 8'h01, 1'b1);

    // Randomized operations with random gaps.
    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end

    // WIDTH=1 instance: full truth table, then random pairs.
    do_op1(1'b0, 1'b0);
    do_op1(1'b0, 1'b1);
    do_op1(1'b1, 1'b0);
    do_op1(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_op1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Drain and make sure every issued operation produced a result.
    wait_idle(ok);
    repeat (6) @(posedge clk);
    #1;
    check("drain_q8", exp_q.size(), 0);
    check("drain_q1", exp1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor; computes diff = A - B over WIDTH clock cycles, LSB first.
- Each cycle uses one full-subtractor cell: the half-subtractor difference/borrow pair plus a stored borrow-in.
- Sits downstream of the combinational difference/borrow cells.
- Provides operand capture, borrow storage, bit sequencing and a start/done handshake to the controller.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  (a - b) mod 2^WIDTH; held until the next result
- borrow_out  output  1  final borrow; 1 iff a < b unsigned

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal shift registers, bit counter and borrow FF cleared.
  - Any in-flight operation is abandoned; no done pulse follows release.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge k: capture a and b into shift regs, borrow FF=0, count=0, go to RUN.
  - start=0: stay in IDLE.
- RUN (edges k+1 .. k+WIDTH), each edge:
  - a0/b0 are the current shift-register LSBs; bin is the borrow FF.
  - d = a0 ^ b0 ^ bin
  - bo = (~a0 & b0) | (~(a0 ^ b0) & bin)
  - Shift d into the MSB of the result shift register; shift the operand regs right by 1.
  - borrow FF = bo; count += 1.
  - At edge k+WIDTH (count reaches WIDTH): go to DONE.
  - On the same edge, diff <= final result register and borrow_out <= final bo.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge: go to IDLE unconditionally.
- Latency:
  - busy high during cycles k+1 .. k+WIDTH.
  - done visible in the cycle after edge k+WIDTH.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Start handling:
  - Ignored in RUN and DONE; no queuing.
  - Operand changes on a/b after capture have no effect.
- Output hold: diff and borrow_out change only on DONE entry or reset. They are stable between operations.
- Counter width: clog2(WIDTH+1) bits; no wrap occurs within an operation.
- WIDTH=1: single RUN cycle; results equal the half-subtractor truth table.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse -> busy for 8 cycles, done 1 cycle later, diff=0x02, borrow_out=0.
- WIDTH=8, a=0x03, b=0x05 -> diff=0xFE, borrow_out=1. Also a=0x00, b=0x01 -> diff=0xFF, borrow_out=1 (full borrow ripple).
- WIDTH=8, a=0xFF, b=0xFF -> diff=0x00, borrow_out=0. Then a=0x80, b=0x7F -> diff=0x01, borrow_out=0. Back-to-back starts issued in the DONE cycle are ignored; a start in IDLE is accepted.
- Start held high and a/b changed mid-RUN (first op a=0x10, b=0x01) -> exactly one operation; diff=0x0F. Next op begins only when start is seen in IDLE.
- rst_n pulled low at RUN cycle 4 of a=0x20, b=0x01 -> all outputs 0 immediately. No done after release; a fresh start then completes normally.
- WIDTH=1 instance, (a,b) = 00, 01, 10, 11 -> (diff,borrow_out) = 00, 11, 10, 00.
